// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues imem word fetches, buffers responses for decode.
// FETCH_MISALIGN_TRAP_EN: misaligned redirect targets halt fetch until realigned.

module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        dec_ready,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [6:0]  opcode,
   output logic [2:0]  fun3,
   output logic [6:0]  fun7,
   output logic        fetch_misalign
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int UW = CW + 1;
   localparam int PW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALT} state_e;
   typedef logic [PW-1:0] ptr_t;
   typedef logic [CW-1:0] cnt_t;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] rsp_pc_q, rsp_pc_d;
   logic [31:0] head_instr_q, head_instr_d;
   logic [31:0] head_pc_q, head_pc_d;
   cnt_t        outst_q, outst_d;
   cnt_t        drop_q, drop_d;
   cnt_t        cnt_q, cnt_d;
   ptr_t        rd_q, rd_d;
   ptr_t        wr_q, wr_d;
   logic        halt_pend_q, halt_pend_d;
   logic        run_q;

   logic [31:0] buf_instr_q [FIFO_DEPTH];
   logic [31:0] buf_pc_q    [FIFO_DEPTH];

   logic          pop;
   logic          push;
   logic          rsp_in;
   logic          fire;
   logic          req_ok;
   logic          trap_req;
   logic [UW-1:0] used;
   logic [31:0]   tgt_pc;

   function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == ptr_t'(FIFO_DEPTH - 1)) ? '0 : p + ptr_t'(1);
   endfunction

   assign tgt_pc = redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_MISALIGN_TRAP_EN
   assign trap_req       = redirect_pc[1:0] != 2'b00;
   assign fetch_misalign = state_q == S_HALT;
`else
   assign trap_req       = 1'b0;
   assign fetch_misalign = 1'b0;
`endif

   // A slot freed by this cycle's pop may be re-credited immediately
   assign pop    = (cnt_q != '0) && dec_ready;
   assign used   = UW'(outst_q) + UW'(cnt_q) - UW'(pop);
   assign req_ok = run_q && (state_q == S_RUN) && !redirect
                   && (used < UW'(FIFO_DEPTH));
   assign fire   = req_ok && imem_req_ready;
   assign rsp_in = imem_rsp_valid && (outst_q != '0);
   assign push   = rsp_in && (drop_q == '0) && !redirect;

   assign imem_req_valid = req_ok;
   assign imem_req_addr  = pc_q;
   assign instr_valid    = cnt_q != '0;
   assign instr          = head_instr_q;
   assign instr_pc       = head_pc_q;
   assign opcode         = head_instr_q[6:0];
   assign fun3           = head_instr_q[14:12];
   assign fun7           = head_instr_q[31:25];

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      rsp_pc_d     = rsp_pc_q;
      outst_d      = outst_q;
      drop_d       = drop_q;
      cnt_d        = cnt_q;
      rd_d         = rd_q;
      wr_d         = wr_q;
      halt_pend_d  = halt_pend_q;
      head_instr_d = head_instr_q;
      head_pc_d    = head_pc_q;

      if (redirect) begin
         pc_d        = tgt_pc;
         rsp_pc_d    = tgt_pc;
         cnt_d       = '0;
         rd_d        = '0;
         wr_d        = '0;
         drop_d      = outst_q - cnt_t'(rsp_in);
         outst_d     = drop_d;
         halt_pend_d = trap_req;
         if (drop_d != '0) begin
            state_d = S_DRAIN;
         end else if (trap_req) begin
            state_d = S_HALT;
         end else begin
            state_d = S_RUN;
         end
      end else begin
         if (fire) begin
            pc_d = pc_q + 32'd4;
         end
         outst_d = outst_q + cnt_t'(fire) - cnt_t'(rsp_in);
         if (rsp_in && (drop_q != '0)) begin
            drop_d = drop_q - cnt_t'(1);
            if (drop_q == cnt_t'(1)) begin
               state_d = halt_pend_q ? S_HALT : S_RUN;
            end
         end
         if (push) begin
            wr_d     = ptr_inc(wr_q);
            rsp_pc_d = rsp_pc_q + 32'd4;
         end
         if (pop) begin
            rd_d = ptr_inc(rd_q);
         end
         cnt_d = cnt_q + cnt_t'(push) - cnt_t'(pop);
      end

      // Head registers track the next-cycle FIFO head, or hold when empty
      if (cnt_d != '0) begin
         if (push && (wr_q == rd_d)) begin
            head_instr_d = imem_rsp_data;
            head_pc_d    = rsp_pc_q;
         end else begin
            head_instr_d = buf_instr_q[rd_d];
            head_pc_d    = buf_pc_q[rd_d];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_RUN;
         pc_q         <= RESET_PC;
         rsp_pc_q     <= RESET_PC;
         outst_q      <= '0;
         drop_q       <= '0;
         cnt_q        <= '0;
         rd_q         <= '0;
         wr_q         <= '0;
         halt_pend_q  <= 1'b0;
         head_instr_q <= '0;
         head_pc_q    <= '0;
         run_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         rsp_pc_q     <= rsp_pc_d;
         outst_q      <= outst_d;
         drop_q       <= drop_d;
         cnt_q        <= cnt_d;
         rd_q         <= rd_d;
         wr_q         <= wr_d;
         halt_pend_q  <= halt_pend_d;
         head_instr_q <= head_instr_d;
         head_pc_q    <= head_pc_d;
         run_q        <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         buf_instr_q[wr_q] <= imem_rsp_data;
         buf_pc_q[wr_q]    <= rsp_pc_q;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit with a latency-configurable memory model.

module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'h0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        dec_ready = 1'b0;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [6:0]  opcode;
   logic [2:0]  fun3;
   logic [6:0]  fun7;
   logic        fetch_misalign;

   always #5 clk = ~clk;

   instr_fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc),
      .dec_ready      (dec_ready),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .opcode         (opcode),
      .fun3           (fun3),
      .fun7           (fun7),
      .fetch_misalign (fetch_misalign)
   );

   typedef struct { logic [31:0] pc; logic [31:0] word; } exp_t;
   typedef struct { logic [31:0] addr; int due; } inf_t;

   exp_t        exp_q[$];
   inf_t        inflight[$];
   logic [31:0] req_log[$];
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          lat = 1;
   bit          en = 1'b0;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_2468;
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic push_stream(input logic [31:0] base, input int n);
      logic [31:0] a;
      for (int i = 0; i < n; i++) begin
         a = base + 32'(4 * i);
         exp_q.push_back('{pc: a, word: word_of(a)});
      end
   endtask

   task automatic wait_sb(input int left, input string name);
      int k = 0;
      while (exp_q.size() > left && k < 400) begin
         step();
         k++;
      end
      checks++;
      if (exp_q.size() > left) begin
         errors++;
         $display("FAIL %s: %0d entries pending, expected <= %0d",
                  name, exp_q.size(), left);
      end
   endtask

   // Request capture and output monitor, sampled mid-cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && imem_req_valid && imem_req_ready) begin
            inflight.push_back('{addr: imem_req_addr, due: cyc + lat});
            req_log.push_back(imem_req_addr);
         end
         if (rst_n && instr_valid && dec_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL sb_extra: got pc=%h instr=%h, expected none",
                        instr_pc, instr);
            end else begin
               e = exp_q.pop_front();
               if (instr_pc !== e.pc || instr !== e.word
                   || opcode !== e.word[6:0] || fun3 !== e.word[14:12]
                   || fun7 !== e.word[31:25]) begin
                  errors++;
                  $display("FAIL sb_instr: got pc=%h instr=%h op=%h, expected pc=%h instr=%h",
                           instr_pc, instr, opcode, e.pc, e.word);
               end
            end
         end
      end
   end

   // Memory responder and decode-ready driver
   initial begin
      forever begin
         @(posedge clk);
         #2;
         cyc++;
         if (!rst_n) begin
            inflight.delete();
            imem_rsp_valid = 1'b0;
         end else if (inflight.size() > 0 && inflight[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word_of(inflight[0].addr);
            void'(inflight.pop_front());
         end else begin
            imem_rsp_valid = 1'b0;
         end
         dec_ready = en && (exp_q.size() > 0);
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int          base;
      logic [31:0] w;

      repeat (3) step();
      at_neg();
      check("rst_valid", instr_valid, 0);
      check("rst_req", imem_req_valid, 0);
      check("rst_addr", imem_req_addr, 0);
      check("rst_instr", instr, 0);
      check("rst_pc", instr_pc, 0);
      check("rst_misalign", fetch_misalign, 0);

      // Release reset with decode stalled
      step();
      rst_n = 1'b1;
      push_stream(32'h0, 16);
      at_neg();
      check("rel_req_gate", imem_req_valid, 0);
      step();
      step();
      at_neg();
      check("lat_c2_valid", instr_valid, 0);
      step();
      at_neg();
      w = word_of(32'h0);
      check("lat_c3_valid", instr_valid, 1);
      check("lat_c3_pc", instr_pc, 0);
      check("lat_c3_opcode", 32'(opcode), 32'(w[6:0]));
      repeat (7) step();
      at_neg();
      check("stall_req_count", 32'(req_log.size()), 2);
      check("stall_req_idle", imem_req_valid, 0);
      check("stall_head_pc", instr_pc, 0);
      check("stall_head_valid", instr_valid, 1);

      step();
      en = 1'b1;
      wait_sb(0, "stream_0");
      for (int i = 0; i < 6; i++) check("seq_addr", req_log[i], 32'(4 * i));

      // Two stale fetches in flight with slow memory
      repeat (4) step();
      lat = 3;
      repeat (2) step();
      redirect = 1'b1;
      redirect_pc = 32'h80;
      step();
      redirect = 1'b0;
      base = req_log.size();
      for (int k = 0; k < 20 && req_log.size() < base + 2; k++) step();
      check("infl_addr0", req_log[base], 32'h80);
      check("infl_addr1", req_log[base+1], 32'h84);
      redirect = 1'b1;
      redirect_pc = 32'h100;
      step();
      redirect = 1'b0;
      exp_q.delete();
      base = req_log.size();
      at_neg();
      check("drain_req_0", imem_req_valid, 0);
      check("drain_valid_0", instr_valid, 0);
      step();
      at_neg();
      check("drain_req_1", imem_req_valid, 0);
      check("drain_valid_1", instr_valid, 0);
      push_stream(32'h100, 60);
      wait_sb(54, "stream_100");
      check("drain_first_addr", req_log[base], 32'h100);

      // Redirect coincident with a response and a pop
      lat = 1;
      repeat (8) step();
      redirect = 1'b1;
      redirect_pc = 32'h40;
      at_neg();
      check("coinc_pre_valid", instr_valid, 1);
      step();
      redirect = 1'b0;
      exp_q.delete();
      base = req_log.size();
      push_stream(32'h40, 20);
      at_neg();
      check("coinc_empty", instr_valid, 0);
      check("coinc_req", imem_req_valid, 1);
      check("coinc_addr", imem_req_addr, 32'h40);
      wait_sb(14, "stream_40");

      // PC wrap at the top of the address space
      redirect = 1'b1;
      redirect_pc = 32'hFFFF_FFF8;
      step();
      redirect = 1'b0;
      exp_q.delete();
      base = req_log.size();
      push_stream(32'hFFFF_FFF8, 12);
      wait_sb(4, "stream_wrap");
      check("wrap_addr0", req_log[base], 32'hFFFF_FFF8);
      check("wrap_addr1", req_log[base+1], 32'hFFFF_FFFC);
      check("wrap_addr2", req_log[base+2], 32'h0);
      check("wrap_addr3", req_log[base+3], 32'h4);

      // Misaligned redirect target
      redirect = 1'b1;
      redirect_pc = 32'h102;
      step();
      redirect = 1'b0;
      exp_q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
      repeat (3) step();
      base = req_log.size();
      for (int i = 0; i < 4; i++) begin
         at_neg();
         check("halt_misalign", fetch_misalign, 1);
         check("halt_req", imem_req_valid, 0);
         check("halt_valid", instr_valid, 0);
         step();
      end
      check("halt_no_reqs", 32'(req_log.size()), 32'(base));
      redirect = 1'b1;
      redirect_pc = 32'h200;
      step();
      redirect = 1'b0;
      base = req_log.size();
      push_stream(32'h200, 8);
      at_neg();
      check("unhalt_misalign", fetch_misalign, 0);
      wait_sb(0, "stream_200");
      check("unhalt_addr", req_log[base], 32'h200);
`else
      base = req_log.size();
      push_stream(32'h100, 8);
      wait_sb(0, "stream_102");
      check("mask_addr", req_log[base], 32'h100);
      check("mask_misalign", fetch_misalign, 0);
`endif

      // Asynchronous reset with a full buffer
      repeat (4) step();
      at_neg();
      check("pre_rst_valid", instr_valid, 1);
      step();
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", instr_valid, 0);
      check("mid_rst_req", imem_req_valid, 0);
      check("mid_rst_addr", imem_req_addr, 0);
      check("mid_rst_instr", instr, 0);
      check("mid_rst_pc", instr_pc, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
